// File: rtl/wishbone_burst_memory.sv
// wishbone_burst_memory: Wishbone B4 slave RAM with byte lanes, incrementing bursts and out-of-range error.
// Optional WBMEM_OUTREG_EN: extra dat_o register, classic-only accesses, ack_o/err_o two cycles after request.
module wishbone_burst_memory #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_BYTES    = 1,
    parameter int BASE_ADDRESS  = 0,
    parameter int MEMORY_SIZE   = 512
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [ADDRESS_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0]    dat_i,
    output logic [DATA_WIDTH-1:0]    dat_o,
    input  logic                     we_i,
    input  logic [DATA_BYTES-1:0]    sel_i,
    input  logic                     stb_i,
    input  logic                     cyc_i,
    input  logic [2:0]               cti_i,
    output logic                     ack_o,
    output logic                     err_o
);
    localparam int AW = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] SIZE = ADDRESS_WIDTH'(MEMORY_SIZE);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                   state, state_n;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] loc, loc_nxt;
    logic [AW-1:0]            rd_adr;
    logic                     valid, valid_nxt, req, burst_req, pend, run, ack_n, err_n, wr;

    assign loc       = adr_i - BASE;
    assign loc_nxt   = loc + ADDRESS_WIDTH'(1);
    assign valid     = loc < SIZE;
    assign valid_nxt = loc_nxt < SIZE;
    assign req       = cyc_i & stb_i & ~ack_o & ~err_o & ~pend & run;

`ifdef WBMEM_OUTREG_EN
    logic                  p_ack, p_err;
    logic [DATA_WIDTH-1:0] dat_q;
    assign pend      = p_ack | p_err;
    assign burst_req = 1'b0;
`else
    assign pend      = 1'b0;
    assign burst_req = cti_i == 3'b010;
`endif

    // Next state, response and write decision; a burst beat prefetches the following word.
    always_comb begin
        state_n = state;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        wr      = 1'b0;
        rd_adr  = loc[AW-1:0];
        if (state == IDLE) begin
            if (req) begin
                ack_n = valid;
                err_n = ~valid;
                wr    = valid & we_i;
                state_n = (valid && burst_req) ? BURST : IDLE;
            end
        end else if (cyc_i && stb_i && ack_o) begin
            rd_adr  = loc_nxt[AW-1:0];
            wr      = valid & we_i;
            ack_n   = valid & burst_req & valid_nxt;
            err_n   = ~valid | (burst_req & ~valid_nxt);
            state_n = (valid && burst_req && valid_nxt) ? BURST : IDLE;
        end else begin
            state_n = IDLE;
        end
    end

    // Goes low with reset and returns one edge after release, so no access is taken while in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) run <= 1'b0;
        else         run <= 1'b1;
    end

    // FSM state plus registered ack/err/data so the bus sees no combinational path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
`ifdef WBMEM_OUTREG_EN
            p_ack <= 1'b0;
            p_err <= 1'b0;
            dat_q <= '0;
`endif
        end else begin
            state <= state_n;
`ifdef WBMEM_OUTREG_EN
            p_ack <= ack_n;
            p_err <= err_n;
            dat_q <= mem[rd_adr];
            ack_o <= p_ack;
            err_o <= p_err;
            dat_o <= dat_q;
`else
            ack_o <= ack_n;
            err_o <= err_n;
            dat_o <= mem[rd_adr];
`endif
        end
    end

    // Byte-lane masked RAM write; read above sees the old word on a same-address write.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DATA_BYTES; b++)
            if (wr && sel_i[b]) mem[loc[AW-1:0]][8*b +: 8] <= dat_i[8*b +: 8];
    end
endmodule

// File: tb/tb_wishbone_burst_memory.sv
// tb_wishbone_burst_memory: scoreboard bench for the burst RAM (16-bit, two byte lanes, 512 words).
module tb_wishbone_burst_memory;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] adr_i, dat_i, dat_o;
    logic        we_i, stb_i, cyc_i, ack_o, err_o;
    logic [1:0]  sel_i;
    logic [2:0]  cti_i;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] mdl [512];
    logic [15:0] exp_q [$];

    always #5 clk_i = ~clk_i;

    wishbone_burst_memory #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(16), .DATA_BYTES(2), .BASE_ADDRESS(0), .MEMORY_SIZE(512)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .we_i(we_i),
        .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .cti_i(cti_i), .ack_o(ack_o), .err_o(err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_bus(input logic c, s, w, input logic [15:0] a, d, input logic [1:0] m, input logic [2:0] t);
        cyc_i = c; stb_i = s; we_i = w; adr_i = a; dat_i = d; sel_i = m; cti_i = t;
    endtask

    task automatic mdl_write(input logic [15:0] a, d, input logic [1:0] m);
        for (int b = 0; b < 2; b++)
            if (m[b]) mdl[a[8:0]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic classic(input logic w, input logic [15:0] a, d, input logic [1:0] m,
                           output logic a0, a1, e1, output logic [15:0] d1, output logic a2);
        tick();
        set_bus(1, 1, w, a, d, m, 3'b000);
        if (a < 16'd512) begin
            if (w) mdl_write(a, d, m);
            else exp_q.push_back(mdl[a[8:0]]);
        end
        @(negedge clk_i);
        a0 = ack_o | err_o;
        tick();
        @(negedge clk_i);
        a1 = ack_o; e1 = err_o; d1 = dat_o;
        tick();
        set_bus(0, 0, 0, 16'd0, 16'd0, 2'b00, 3'b000);
        @(negedge clk_i);
        a2 = ack_o | err_o;
    endtask

    task automatic test_reset();
        set_bus(0, 0, 0, 16'd0, 16'd0, 2'b00, 3'b000);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b0) begin fails++; $display("FAIL rst_ack: got %b want 0", ack_o); end
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err_o); end
        tests++; if (dat_o !== 16'h0) begin fails++; $display("FAIL rst_dat: got %h want 0000", dat_o); end
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_classic();
        logic a0, a1, e1, a2;
        logic [15:0] d1, exp;
        classic(1, 16'd3, 16'h00A5, 2'b11, a0, a1, e1, d1, a2);
        tests++; if (a0 !== 1'b0) begin fails++; $display("FAIL cl_wr_pre: got %b want 0", a0); end
        tests++; if (a1 !== 1'b1 || e1 !== 1'b0) begin fails++; $display("FAIL cl_wr_ack: got ack %b err %b want 1/0", a1, e1); end
        tests++; if (a2 !== 1'b0) begin fails++; $display("FAIL cl_wr_post: got %b want 0", a2); end
        classic(0, 16'd3, 16'h0, 2'b11, a0, a1, e1, d1, a2);
        exp = exp_q.pop_front();
        tests++; if (a0 !== 1'b0 || a1 !== 1'b1 || a2 !== 1'b0) begin fails++; $display("FAIL cl_rd_ack: got %b%b%b want 010", a0, a1, a2); end
        tests++; if (d1 !== exp || d1 !== 16'h00A5) begin fails++; $display("FAIL cl_rd_dat: got %h want %h", d1, exp); end
    endtask

    task automatic test_byte_lanes();
        logic a0, a1, e1, a2;
        logic [15:0] d1, exp;
        classic(1, 16'd0, 16'h1234, 2'b11, a0, a1, e1, d1, a2);
        classic(1, 16'd0, 16'hABCD, 2'b01, a0, a1, e1, d1, a2);
        classic(0, 16'd0, 16'h0, 2'b11, a0, a1, e1, d1, a2);
        exp = exp_q.pop_front();
        tests++; if (d1 !== exp || d1 !== 16'h12CD) begin fails++; $display("FAIL lane_lo: got %h want %h", d1, exp); end
        classic(1, 16'd0, 16'hEE00, 2'b10, a0, a1, e1, d1, a2);
        classic(0, 16'd0, 16'h0, 2'b11, a0, a1, e1, d1, a2);
        exp = exp_q.pop_front();
        tests++; if (d1 !== exp || d1 !== 16'hEECD) begin fails++; $display("FAIL lane_hi: got %h want %h", d1, exp); end
    endtask

    task automatic test_burst_read();
        logic a0, a1, e1, a2;
        logic [15:0] d1, exp;
        for (int i = 0; i < 4; i++) classic(1, 16'(10 + i), 16'(i + 1), 2'b11, a0, a1, e1, d1, a2);
        tick();
        set_bus(1, 1, 0, 16'd10, 16'd0, 2'b11, 3'b010);
        exp_q.push_back(mdl[10]);
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b0) begin fails++; $display("FAIL brd_req: got %b want 0", ack_o); end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k > 0) begin
                set_bus(1, 1, 0, 16'(10 + k), 16'd0, 2'b11, k == 3 ? 3'b111 : 3'b010);
                exp_q.push_back(mdl[10 + k]);
            end
            @(negedge clk_i);
            exp = exp_q.pop_front();
            tests++; if (ack_o !== 1'b1 || dat_o !== exp) begin fails++; $display("FAIL brd_beat%0d: got ack %b dat %h want 1 %h", k, ack_o, dat_o, exp); end
        end
        tick();
        set_bus(0, 0, 0, 16'd0, 16'd0, 2'b00, 3'b000);
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b0) begin fails++; $display("FAIL brd_end: got %b want 0", ack_o); end
    endtask

    task automatic test_error();
        logic a0, a1, e1, a2;
        logic [15:0] d1, exp;
        classic(1, 16'd88, 16'h5858, 2'b11, a0, a1, e1, d1, a2);
        classic(1, 16'd510, 16'h0510, 2'b11, a0, a1, e1, d1, a2);
        classic(1, 16'd511, 16'h0511, 2'b11, a0, a1, e1, d1, a2);
        classic(0, 16'd600, 16'h0, 2'b11, a0, a1, e1, d1, a2);
        tests++; if (a1 !== 1'b0 || e1 !== 1'b1 || a2 !== 1'b0) begin fails++; $display("FAIL err_rd600: got ack %b err %b after %b want 0 1 0", a1, e1, a2); end
        classic(1, 16'd600, 16'hDEAD, 2'b11, a0, a1, e1, d1, a2);
        tests++; if (a1 !== 1'b0 || e1 !== 1'b1) begin fails++; $display("FAIL err_wr600: got ack %b err %b want 0 1", a1, e1); end
        classic(0, 16'd88, 16'h0, 2'b11, a0, a1, e1, d1, a2);
        exp = exp_q.pop_front();
        tests++; if (a1 !== 1'b1 || d1 !== exp) begin fails++; $display("FAIL err_alias88: got %h want %h", d1, exp); end
        classic(0, 16'd511, 16'h0, 2'b11, a0, a1, e1, d1, a2);
        exp = exp_q.pop_front();
        tests++; if (a1 !== 1'b1 || e1 !== 1'b0 || d1 !== exp) begin fails++; $display("FAIL edge511: got ack %b dat %h want 1 %h", a1, d1, exp); end
        classic(0, 16'd512, 16'h0, 2'b11, a0, a1, e1, d1, a2);
        tests++; if (a1 !== 1'b0 || e1 !== 1'b1) begin fails++; $display("FAIL edge512: got ack %b err %b want 0 1", a1, e1); end
        tick();
        set_bus(1, 1, 0, 16'd510, 16'd0, 2'b11, 3'b010);
        exp_q.push_back(mdl[510]);
        tick();
        @(negedge clk_i);
        exp = exp_q.pop_front();
        tests++; if (ack_o !== 1'b1 || dat_o !== exp) begin fails++; $display("FAIL wrap510: got ack %b dat %h want 1 %h", ack_o, dat_o, exp); end
        tick();
        set_bus(1, 1, 0, 16'd511, 16'd0, 2'b11, 3'b010);
        exp_q.push_back(mdl[511]);
        @(negedge clk_i);
        exp = exp_q.pop_front();
        tests++; if (ack_o !== 1'b1 || dat_o !== exp) begin fails++; $display("FAIL wrap511: got ack %b dat %h want 1 %h", ack_o, dat_o, exp); end
        tick();
        set_bus(1, 1, 0, 16'd512, 16'd0, 2'b11, 3'b010);
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b0 || err_o !== 1'b1) begin fails++; $display("FAIL wrap512: got ack %b err %b want 0 1", ack_o, err_o); end
        tick();
        set_bus(0, 0, 0, 16'd0, 16'd0, 2'b00, 3'b000);
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b0 || err_o !== 1'b0) begin fails++; $display("FAIL wrap_end: got ack %b err %b want 0 0", ack_o, err_o); end
    endtask

    task automatic test_burst_gap();
        logic a0, a1, e1, a2;
        logic [15:0] d1, exp;
        tick();
        set_bus(1, 1, 1, 16'd20, 16'h2000, 2'b11, 3'b010);
        mdl_write(16'd20, 16'h2000, 2'b11);
        tick();
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b1) begin fails++; $display("FAIL gap_b1: got %b want 1", ack_o); end
        tick();
        set_bus(1, 1, 1, 16'd21, 16'h2101, 2'b11, 3'b010);
        mdl_write(16'd21, 16'h2101, 2'b11);
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b1) begin fails++; $display("FAIL gap_b2: got %b want 1", ack_o); end
        tick();
        set_bus(1, 0, 1, 16'd22, 16'hBAD0, 2'b11, 3'b010);
        tick();
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b0) begin fails++; $display("FAIL gap_low: got %b want 0", ack_o); end
        tick();
        set_bus(1, 1, 1, 16'd22, 16'h2202, 2'b11, 3'b010);
        mdl_write(16'd22, 16'h2202, 2'b11);
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b0) begin fails++; $display("FAIL gap_restart_req: got %b want 0", ack_o); end
        tick();
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b1) begin fails++; $display("FAIL gap_b3: got %b want 1", ack_o); end
        tick();
        set_bus(1, 1, 1, 16'd23, 16'h2303, 2'b11, 3'b111);
        mdl_write(16'd23, 16'h2303, 2'b11);
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b1) begin fails++; $display("FAIL gap_b4: got %b want 1", ack_o); end
        tick();
        set_bus(0, 0, 0, 16'd0, 16'd0, 2'b00, 3'b000);
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b0) begin fails++; $display("FAIL gap_end: got %b want 0", ack_o); end
        for (int i = 0; i < 4; i++) begin
            classic(0, 16'(20 + i), 16'h0, 2'b11, a0, a1, e1, d1, a2);
            exp = exp_q.pop_front();
            tests++; if (a1 !== 1'b1 || d1 !== exp) begin fails++; $display("FAIL gap_word%0d: got %h want %h", 20 + i, d1, exp); end
        end
    endtask

    task automatic test_reset_burst();
        logic a0, a1, e1, a2;
        logic [15:0] d1, exp;
        classic(1, 16'd0, 16'h1111, 2'b11, a0, a1, e1, d1, a2);
        classic(1, 16'd1, 16'h2222, 2'b11, a0, a1, e1, d1, a2);
        tick();
        set_bus(1, 1, 1, 16'd0, 16'h5555, 2'b11, 3'b010);
        mdl_write(16'd0, 16'h5555, 2'b11);
        tick();
        @(negedge clk_i);
        tests++; if (ack_o !== 1'b1) begin fails++; $display("FAIL rstb_b1: got %b want 1", ack_o); end
        tick();
        set_bus(1, 1, 1, 16'd1, 16'h6666, 2'b11, 3'b010);
        #2;
        rst_ni = 1'b0;
        #1;
        tests++; if (ack_o !== 1'b0 || err_o !== 1'b0) begin fails++; $display("FAIL rstb_async: got ack %b err %b want 0 0", ack_o, err_o); end
        tick();
        set_bus(0, 0, 0, 16'd0, 16'd0, 2'b00, 3'b000);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            classic(0, 16'(i), 16'h0, 2'b11, a0, a1, e1, d1, a2);
            exp = exp_q.pop_front();
            tests++; if (a1 !== 1'b1 || d1 !== exp) begin fails++; $display("FAIL rstb_word%0d: got ack %b dat %h want 1 %h", i, a1, d1, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_classic();
        test_byte_lanes();
        test_burst_read();
        test_error();
        test_burst_gap();
        test_reset_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
